// File: rtl/fetch_pkg.sv
// Shared constants and types for the IF-stage fetch controller and the PC register.
package fetch_pkg;

  localparam int PC_W = 30;

  localparam logic [PC_W-1:0] START_ADDR = 30'h0000C00;
  localparam logic [PC_W-1:0] TRAP_ADDR  = 30'h0000C40;
  localparam logic [PC_W-1:0] PC_ONE     = 30'd1;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// IF-stage fetch controller: sequences PC updates, instruction fetch handshake,
// IF/ID valid and pipeline flush, resolving trap/redirect/stall/halt by priority.
module fetch_ctrl #(
  parameter logic [fetch_pkg::PC_W-1:0] START_ADDR = fetch_pkg::START_ADDR,
  parameter logic [fetch_pkg::PC_W-1:0] TRAP_ADDR  = fetch_pkg::TRAP_ADDR
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [fetch_pkg::PC_W-1:0]  pc_cur,
  input  logic                        stall,
  input  logic                        halt,
  input  logic                        redirect_valid,
  input  logic [fetch_pkg::PC_W-1:0]  redirect_target,
  input  logic                        trap_valid,
  input  logic                        imem_ready,
  output logic                        imem_req,
  output logic [fetch_pkg::PC_W-1:0]  imem_addr,
  output logic [fetch_pkg::PC_W-1:0]  npc,
  output logic                        pc_write,
  output logic                        if_valid,
  output logic                        flush,
  output logic                        halted
);
  import fetch_pkg::*;

  fetch_state_t    state_q, state_d;
  logic            pend_valid_q, pend_valid_d;
  logic            pend_trap_q, pend_trap_d;
  logic [PC_W-1:0] pend_target_q, pend_target_d;

  logic            event_any;
  logic [PC_W-1:0] event_target;
  logic            merged_trap;
  logic [PC_W-1:0] merged_target;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= BOOT;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= START_ADDR;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Trap outranks redirect whenever both arrive together.
  always_comb begin
    event_any    = trap_valid | redirect_valid;
    event_target = trap_valid ? TRAP_ADDR : redirect_target;
  end

  // While draining, a newer trap always wins; a newer redirect only replaces a redirect.
  always_comb begin
    merged_trap   = pend_trap_q;
    merged_target = pend_target_q;
    if (trap_valid) begin
      merged_trap   = 1'b1;
      merged_target = TRAP_ADDR;
    end else if (redirect_valid && !pend_trap_q) begin
      merged_target = redirect_target;
    end
  end

  always_comb begin
    imem_req  = ((state_q == FETCH) || (state_q == DRAIN)) && !reset;
    imem_addr = reset ? START_ADDR : pc_cur;
    halted    = (state_q == HALTED) && !reset;
  end

  always_comb begin
    state_d       = state_q;
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;
    npc           = pc_cur;
    pc_write      = 1'b0;
    if_valid      = 1'b0;
    flush         = 1'b0;

    if (reset) begin
      npc          = START_ADDR;
      state_d      = BOOT;
      pend_valid_d = 1'b0;
      pend_trap_d  = 1'b0;
    end else begin
      unique case (state_q)
        BOOT: begin
          if (event_any) begin
            pc_write = 1'b1;
            npc      = event_target;
            flush    = 1'b1;
          end
          state_d = FETCH;
        end

        FETCH: begin
          if (event_any && imem_ready) begin
            pc_write = 1'b1;
            npc      = event_target;
            flush    = 1'b1;
          end else if (event_any) begin
            // Response still outstanding: remember where to go once it lands.
            flush         = 1'b1;
            pend_valid_d  = 1'b1;
            pend_trap_d   = trap_valid;
            pend_target_d = event_target;
            state_d       = DRAIN;
          end else if (imem_ready && !stall) begin
            if_valid = 1'b1;
            pc_write = 1'b1;
            npc      = pc_cur + PC_ONE;
            if (halt) begin
              state_d = HALTED;
            end
          end
        end

        DRAIN: begin
          flush         = event_any;
          pend_trap_d   = merged_trap;
          pend_target_d = merged_target;
          if (imem_ready) begin
            pc_write     = 1'b1;
            npc          = merged_target;
            pend_valid_d = 1'b0;
            pend_trap_d  = 1'b0;
            state_d      = halt ? HALTED : FETCH;
          end
        end

        HALTED: begin
          if (event_any) begin
            pc_write = 1'b1;
            npc      = event_target;
            flush    = 1'b1;
          end
          if (!halt) begin
            state_d = FETCH;
          end
        end

        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

endmodule
